// File: rtl/breathe_pkg.sv
// Shared types and helpers for the breathe_gen envelope generator.
// The gamma map is only used when the block is built with GAMMA_EN defined.
package breathe_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRise,
    StHoldHi,
    StFall,
    StHoldLo
  } breathe_state_e;

  // All-ones value for a w-bit level; the shift wraps to 0 for w=32, giving all ones.
  function automatic logic [31:0] max_level(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // (l*(l+1)) >> w, with a product twice as wide as the level.
  function automatic logic [31:0] gamma_map(input logic [31:0] lvl, input int unsigned w);
    logic [63:0] prod;
    prod = 64'(lvl) * (64'(lvl) + 64'd1);
    return 32'(prod >> w);
  endfunction

endpackage

// File: rtl/breathe_gen_if.sv
// Control/output bundle between breathe_gen (master) and its pwm-side consumer (slave).
interface breathe_gen_if #(
  parameter int unsigned CTR_LEN = 8
);
  logic               en;
  logic [CTR_LEN-1:0] value;
  logic               rising;
  logic               cycle_done;

  modport master (input en, output value, output rising, output cycle_done);
  modport slave  (output en, input value, input rising, input cycle_done);
endinterface

// File: rtl/tick_gen.sv
// STEP_DIV prescaler: one-cycle tick every STEP_DIV clocks while clear is low.
module tick_gen #(
  parameter int unsigned STEP_DIV = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/breathe_gen.sv
// Breathing brightness envelope for the pwm compare input: ramp up, hold, ramp down, hold.
// Define GAMMA_EN to pass the level through the (l*(l+1))>>CTR_LEN gamma map.
module breathe_gen
  import breathe_pkg::*;
#(
  parameter int unsigned CTR_LEN    = 8,
  parameter int unsigned STEP_DIV   = 65536,
  parameter int unsigned HOLD_STEPS = 64
) (
  input logic          clk,
  input logic          rst,
  breathe_gen_if.master bus
);

  localparam logic [CTR_LEN-1:0] LevelMax = CTR_LEN'(max_level(CTR_LEN));
  localparam int unsigned HoldW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  breathe_state_e     state_q, state_d;
  logic [CTR_LEN-1:0] level_q, level_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [CTR_LEN-1:0] value_q, value_d;
  logic               rising_q, done_q, done_d;
  logic               en, tick;

  assign en = bus.en;

  tick_gen #(
    .STEP_DIV(STEP_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == StIdle || !en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (!en) begin
      // Dropping enable abandons the envelope immediately, no ramp-down.
      state_d = StIdle;
      level_d = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StRise;
        StRise: begin
          if (tick) begin
            if (level_q != LevelMax) begin
              level_d = level_q + CTR_LEN'(1);
            end else begin
              state_d = (HOLD_STEPS > 0) ? StHoldHi : StFall;
            end
          end
        end
        StHoldHi, StHoldLo: begin
          if (tick) begin
            if (hold_q == HoldLast) begin
              hold_d  = '0;
              state_d = (state_q == StHoldHi) ? StFall : StRise;
              done_d  = (state_q == StHoldLo);
            end else begin
              hold_d = hold_q + HoldW'(1);
            end
          end
        end
        StFall: begin
          if (tick) begin
            if (level_q != '0) begin
              level_d = level_q - CTR_LEN'(1);
            end else if (HOLD_STEPS > 0) begin
              state_d = StHoldLo;
            end else begin
              state_d = StRise;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
`ifdef GAMMA_EN
    value_d = CTR_LEN'(gamma_map(32'(level_q), CTR_LEN));
`else
    value_d = level_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      level_q  <= '0;
      hold_q   <= '0;
      value_q  <= '0;
      rising_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      value_q  <= value_d;
      rising_q <= (state_q == StRise) || (state_q == StHoldHi);
      done_q   <= done_d;
    end
  end

  assign bus.value      = value_q;
  assign bus.rising     = rising_q;
  assign bus.cycle_done = done_q;

endmodule
